// File: rtl/stack.sv
// Synchronous LIFO stack of DEPTH x WIDTH words with registered pop data.
// Optional sticky overflow/underflow flag on port err when STACK_ERR_EN is defined.
module stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
`ifdef STACK_ERR_EN
    output logic             empty,
    output logic             err
`else
    output logic             empty
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_data_out;
    logic [CW-1:0]    w_count_nxt;
    logic [AW-1:0]    w_top_idx;
    logic [AW-1:0]    w_wr_idx;
    logic             w_full;
    logic             w_empty;
    logic             w_push_only;
    logic             w_pop_only;
    logic             w_replace;
    logic             w_wr_en;
    logic             w_rd_en;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == {CW{1'b0}});
    // At count == DEPTH the low bits wrap to zero, so subtracting one still lands on DEPTH-1.
    assign w_top_idx = r_count[AW-1:0] - {{(AW-1){1'b0}}, 1'b1};

    // Push+pop on an empty stack degenerates to a plain push.
    assign w_replace   = push & pop & ~w_empty;
    assign w_push_only = push & (~pop | w_empty) & ~w_full;
    assign w_pop_only  = pop & ~push & ~w_empty;
    assign w_wr_en     = w_push_only | w_replace;
    assign w_rd_en     = w_pop_only | w_replace;

    // Write address: top slot for a replace, next free slot for a push.
    always_comb begin
        w_wr_idx = r_count[AW-1:0];
        if (w_replace) begin
            w_wr_idx = w_top_idx;
        end else begin
            w_wr_idx = r_count[AW-1:0];
        end
    end

    // Occupancy update.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push_only, w_pop_only})
            2'b10:   w_count_nxt = r_count + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   w_count_nxt = r_count - {{(CW-1){1'b0}}, 1'b1};
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage array; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= data_in;
        end
    end

    // Count and registered pop data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count    <= {CW{1'b0}};
            r_data_out <= {WIDTH{1'b0}};
        end else begin
            r_count <= w_count_nxt;
            if (w_rd_en) begin
                r_data_out <= r_mem[w_top_idx];
            end
        end
    end

    assign data_out = r_data_out;
    assign full     = w_full;
    assign empty    = w_empty;

`ifdef STACK_ERR_EN
    logic r_err;
    logic w_overflow;
    logic w_underflow;

    assign w_overflow  = push & ~pop & w_full;
    assign w_underflow = pop & ~push & w_empty;

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (w_overflow | w_underflow) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end

    assign err = r_err;
`endif

endmodule

// File: tb/tb_stack.sv
// Directed, table-driven bench for the stack LIFO (default WIDTH=8, DEPTH=8).
// Checks err too when STACK_ERR_EN is defined for the build.
module tb_stack;

    logic       clk;
    logic       reset;
    logic       push;
    logic       pop;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
`ifdef STACK_ERR_EN
    logic       err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       push;
        logic       pop;
        logic [7:0] din;
        logic [7:0] exp_dout;
        logic       exp_full;
        logic       exp_empty;
        logic       exp_err;
    } vec_t;

    vec_t vecs[$];

    stack #(.WIDTH(8), .DEPTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .data_in  (data_in),
        .data_out (data_out),
        .full     (full),
`ifdef STACK_ERR_EN
        .empty    (empty),
        .err      (err)
`else
        .empty    (empty)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [7:0] d, input logic f,
                              input logic e, input logic er);
        check({tag, " data_out"}, {24'd0, data_out}, {24'd0, d});
        check({tag, " full"},     {31'd0, full},     {31'd0, f});
        check({tag, " empty"},    {31'd0, empty},    {31'd0, e});
`ifdef STACK_ERR_EN
        check({tag, " err"},      {31'd0, err},      {31'd0, er});
`else
        if (er === 1'bx) $display("unexpected x in expected err");
`endif
    endtask

    task automatic step(input logic p, input logic q, input logic [7:0] d);
        push    = p;
        pop     = q;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic p, input logic q, input logic [7:0] d,
                       input logic [7:0] ed, input logic ef, input logic ee, input logic er);
        vec_t v;
        v.push = p; v.pop = q; v.din = d;
        v.exp_dout = ed; v.exp_full = ef; v.exp_empty = ee; v.exp_err = er;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        push = 1'b0; pop = 1'b0; data_in = 8'h00;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
    endtask

    initial begin
        // Pushes AA BB CC, idle, three pops
        add(1'b1, 1'b0, 8'hAA, 8'h00, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 8'hBB, 8'h00, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 8'hCC, 8'h00, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 8'h00, 8'hCC, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 8'h00, 8'hBB, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 8'h00, 8'hAA, 1'b0, 1'b1, 1'b0);
        // Fill with 01..08, overflow push of FF is dropped
        for (int i = 1; i <= 8; i++)
            add(1'b1, 1'b0, 8'(i), 8'hAA, (i == 8), 1'b0, 1'b0);
        add(1'b1, 1'b0, 8'hFF, 8'hAA, 1'b1, 1'b0, 1'b1);
        for (int i = 8; i >= 1; i--)
            add(1'b0, 1'b1, 8'h00, 8'(i), 1'b0, (i == 1), 1'b1);
        // Underflow pop holds data, empty push+pop acts as push
        add(1'b0, 1'b1, 8'h00, 8'h01, 1'b0, 1'b1, 1'b1);
        add(1'b1, 1'b1, 8'h5A, 8'h01, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h00, 8'h5A, 1'b0, 1'b1, 1'b1);
        // Top replace
        add(1'b1, 1'b0, 8'hAA, 8'h5A, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b0, 8'hBB, 8'h5A, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b1, 8'h77, 8'hBB, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h00, 8'h77, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h00, 8'hAA, 1'b0, 1'b1, 1'b1);

        do_reset();
        check_outs("reset", 8'h00, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].push, vecs[i].pop, vecs[i].din);
            check_outs($sformatf("vec%0d", i), vecs[i].exp_dout, vecs[i].exp_full,
                       vecs[i].exp_empty, vecs[i].exp_err);
        end

        // Replace while full, then drain to confirm replaced top and ordering
        do_reset();
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 8'(8'h10 + i));
        check_outs("fill2", 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'hE7);
        check_outs("full_replace", 8'h18, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h00);
        check_outs("pop_replaced", 8'hE7, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h00);
        check_outs("pop_below", 8'h17, 1'b0, 1'b0, 1'b0);

        // Empty push+pop never flags; a plain underflow pop does
        do_reset();
        step(1'b1, 1'b1, 8'h3C);
        check_outs("empty_pp", 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h00);
        check_outs("pop_3c", 8'h3C, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 8'h00);
        check_outs("underflow", 8'h3C, 1'b0, 1'b1, 1'b1);

        // Asynchronous reset mid-sequence with a push pending
        do_reset();
        step(1'b1, 1'b0, 8'h11);
        step(1'b1, 1'b0, 8'h22);
        step(1'b0, 1'b1, 8'h00);
        check_outs("pre_rst", 8'h22, 1'b0, 1'b0, 1'b0);
        push = 1'b1; data_in = 8'h99;
        #2;
        reset = 1'b0;
        #1;
        check_outs("async_rst", 8'h00, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check_outs("rst_held", 8'h00, 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        step(1'b0, 1'b1, 8'h00);
        check_outs("after_rst", 8'h00, 1'b0, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
